layered_objects_mux: RTL
========================

# layered_objects_mux

Parametrised N-layer pixel compositor for the VGA path. Each cycle it chooses the highest-priority enabled, non-transparent layer, falling back to background, and drives 24-bit RGB through a 2-stage pipeline. It also records per-frame layer collisions for game logic such as hits and wall contact. It sits between the object drawers (tanks, missiles, bricks, …) and the VGA controller.

## Interface
Parameters:
- N_LAYERS, 6: number of object layers (2..16); index 0 has the highest priority.
- RGB_W, 8: width of each layer colour; only 8 (RRRGGGBB) and 24 (RGB888) are legal.
- TRANSPARENT, 8'hFF: colour key. A layer pixel equal to this value (RGB_W wide) counts as not drawing.

Ports:
- clk  in  1  pixel clock.
- reset  in  1  synchronous, active-high reset.
- start_of_frame  in  1  one-cycle pulse at the first pixel of each frame.
- pix_valid  in  1  the current cycle carries an active-area pixel.
- layer_mask_in  in  N_LAYERS  layer enables, sampled only on start_of_frame.
- draw_req  in  N_LAYERS  per-layer drawing request.
- layer_rgb  in  N_LAYERS*RGB_W  layer colours; layer i is at [i*RGB_W +: RGB_W].
- bg_rgb  in  RGB_W  background colour.
- red_out / green_out / blue_out  out  8 each  composited colour.
- pix_valid_out  out  1  pix_valid delayed to match the RGB outputs.
- winner_idx  out  $clog2(N_LAYERS)  index of the winning layer (0 when the winner is background).
- winner_bg  out  1  background won.
- collision  out  N_LAYERS  collision flags for the completed frame.
- collision_stb  out  1  one-cycle pulse when collision updates.

## Operation
- Active mask: register `act_mask` loads layer_mask_in on start_of_frame. After reset it is all ones.
- Layer drawing: layer i draws when draw_req[i], act_mask[i] (the value in force this cycle, before any update), and layer_rgb_i != TRANSPARENT.
- Winner: the lowest-index drawing layer. If no layer draws, background wins and winner_bg=1.
- Stage 1 registers:
  - the selected colour;
  - winner_idx and winner_bg;
  - pix_valid.
- Stage 2 expands the colour and registers the outputs.
- Expansion for RGB_W=8, with r=c[7:5], g=c[4:2], b=c[1:0]:
  - red = {r,r,r[2:1]};
  - green = {g,g,g[2:1]};
  - blue = {b,b,b,b}.
  - Examples: 8'hE0 gives red FF; 8'h20 gives red 24.
- Expansion for RGB_W=24: pass-through, with red in bits [23:16].
- Outputs while pix_valid=0: the pipeline still computes, but red/green/blue are forced to 0 in stage 2 (blanking).
- Collision accumulation: in a cycle with pix_valid=1 and two or more drawing layers, every drawing layer sets its bit in `coll_acc`.
- Frame end (start_of_frame): collision <= coll_acc OR'd with the current cycle's hits, and coll_acc clears.
  - The pixel on the start_of_frame cycle belongs to the old frame for collision purposes.
  - That same cycle already uses the new act_mask only from the next cycle onward.
  - collision_stb goes high for exactly one cycle, the cycle after start_of_frame.
- Back-to-back start_of_frame pulses: each pulse produces its own strobe and snapshot. A snapshot may be all zero.
- Reset values:
  - all outputs 0;
  - act_mask all ones;
  - coll_acc 0;
  - pipeline valids 0.
- Reset mid-frame discards accumulated collisions and in-flight pixels.

## Timing
- Latency from pix_valid/draw_req/layer_rgb to the RGB outputs, pix_valid_out and winner_idx: exactly 2 cycles. Throughput is 1 pixel per cycle with no stalls.
- start_of_frame to collision_stb: 1 cycle. The collision output is stable until the next strobe.
- layer_mask_in affects winner selection starting with the pixel presented 1 cycle after start_of_frame.
- No combinational path from any input to any output.

## Configuration
- LAYERS_COLLISION_EN defined: coll_acc, the collision register and collision_stb are implemented as described above.
- LAYERS_COLLISION_EN undefined: collision and collision_stb are tied to 0, and no accumulation logic is synthesised. Compositing is unchanged.

## Test plan
- Priority: N_LAYERS=6, RGB_W=8, draw_req=6'b001100, layer 2=8'hE0, layer 3=8'h1C, pix_valid=1 → two cycles later winner_idx=2, red_out=FF, green_out=00, blue_out=00.
- Transparency: draw_req[0]=1 with layer 0=8'hFF, layer 4=8'h03 drawing → winner_idx=4, blue_out=FF. If only layer 0 requests, then winner_bg=1 and the output is the expanded bg_rgb.
- Mask: layer_mask_in=6'b111110 with a start_of_frame pulse; layer 0 drawing 8'hE0 on the next pixel → layer 0 is ignored, and background or the next layer wins.
- Collision: layers 1 and 5 draw together on one valid pixel mid-frame, then start_of_frame → collision_stb pulses 1 cycle later, collision=6'b100010. The next frame has no overlap → collision=0.
- Blanking and reset: pix_valid=0 with layers drawing → RGB=0 and no collision recorded. Assert reset mid-frame, then start_of_frame → collision=0 and all outputs 0 during reset.
- Build without LAYERS_COLLISION_EN: rerun the collision scenario → collision and collision_stb stay 0, and RGB results are identical.

Source files
------------

// File: rtl/layered_objects_mux.sv
// N-layer priority pixel compositor with a 2-stage pipeline and per-frame collision capture.
// Optional feature: define LAYERS_COLLISION_EN to build the collision accumulator and strobe.
module layered_objects_mux #(
  parameter int               N_LAYERS    = 6,
  parameter int               RGB_W       = 8,
  parameter logic [RGB_W-1:0] TRANSPARENT = 8'hFF
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start_of_frame,
  input  logic                          pix_valid,
  input  logic [N_LAYERS-1:0]           layer_mask_in,
  input  logic [N_LAYERS-1:0]           draw_req,
  input  logic [N_LAYERS*RGB_W-1:0]     layer_rgb,
  input  logic [RGB_W-1:0]              bg_rgb,
  output logic [7:0]                    red_out,
  output logic [7:0]                    green_out,
  output logic [7:0]                    blue_out,
  output logic                          pix_valid_out,
  output logic [$clog2(N_LAYERS)-1:0]   winner_idx,
  output logic                          winner_bg,
  output logic [N_LAYERS-1:0]           collision,
  output logic                          collision_stb
);

  localparam int IDX_W = $clog2(N_LAYERS);

  logic [N_LAYERS-1:0] r_act_mask;
  logic [N_LAYERS-1:0] w_draw;
  logic [RGB_W-1:0]    w_sel;
  logic [IDX_W-1:0]    w_win_idx;
  logic                w_win_bg;

  logic [RGB_W-1:0]    r_s1_color;
  logic [IDX_W-1:0]    r_s1_idx;
  logic                r_s1_bg;
  logic                r_s1_valid;

  logic [7:0]          w_exp_r;
  logic [7:0]          w_exp_g;
  logic [7:0]          w_exp_b;

  // The mask only changes at frame boundaries; the sof pixel still sees the old mask.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_act_mask <= '1;
    end else if (start_of_frame) begin
      r_act_mask <= layer_mask_in;
    end
  end

  for (genvar gi = 0; gi < N_LAYERS; gi++) begin : g_draw
    assign w_draw[gi] = draw_req[gi] & r_act_mask[gi] &
                        (layer_rgb[gi*RGB_W +: RGB_W] != TRANSPARENT);
  end

  // Scan from the lowest priority upward so the lowest drawing index is the last write.
  always_comb begin
    w_sel     = bg_rgb;
    w_win_idx = '0;
    w_win_bg  = 1'b1;
    for (int i = N_LAYERS - 1; i >= 0; i--) begin
      if (w_draw[i]) begin
        w_sel     = layer_rgb[i*RGB_W +: RGB_W];
        w_win_idx = IDX_W'(i);
        w_win_bg  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_color <= '0;
      r_s1_idx   <= '0;
      r_s1_bg    <= 1'b0;
      r_s1_valid <= 1'b0;
    end else begin
      r_s1_color <= w_sel;
      r_s1_idx   <= w_win_idx;
      r_s1_bg    <= w_win_bg;
      r_s1_valid <= pix_valid;
    end
  end

  if (RGB_W == 8) begin : g_exp8
    // RRRGGGBB replicated up to 8 bits per channel so full scale maps to FF.
    assign w_exp_r = {r_s1_color[7:5], r_s1_color[7:5], r_s1_color[7:6]};
    assign w_exp_g = {r_s1_color[4:2], r_s1_color[4:2], r_s1_color[4:3]};
    assign w_exp_b = {4{r_s1_color[1:0]}};
  end else begin : g_exp24
    assign w_exp_r = r_s1_color[23:16];
    assign w_exp_g = r_s1_color[15:8];
    assign w_exp_b = r_s1_color[7:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      red_out       <= '0;
      green_out     <= '0;
      blue_out      <= '0;
      pix_valid_out <= 1'b0;
      winner_idx    <= '0;
      winner_bg     <= 1'b0;
    end else begin
      red_out       <= r_s1_valid ? w_exp_r : 8'h00;
      green_out     <= r_s1_valid ? w_exp_g : 8'h00;
      blue_out      <= r_s1_valid ? w_exp_b : 8'h00;
      pix_valid_out <= r_s1_valid;
      winner_idx    <= r_s1_idx;
      winner_bg     <= r_s1_bg;
    end
  end

`ifdef LAYERS_COLLISION_EN
  logic [N_LAYERS-1:0] w_hits;
  logic [N_LAYERS-1:0] r_coll_acc;
  logic [N_LAYERS-1:0] r_collision;
  logic                r_coll_stb;

  // x & (x-1) is nonzero exactly when two or more layers draw.
  assign w_hits = (pix_valid && ((w_draw & (w_draw - N_LAYERS'(1))) != '0)) ? w_draw : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_coll_acc  <= '0;
      r_collision <= '0;
      r_coll_stb  <= 1'b0;
    end else begin
      r_coll_stb <= start_of_frame;
      if (start_of_frame) begin
        r_collision <= r_coll_acc | w_hits;
        r_coll_acc  <= '0;
      end else begin
        r_coll_acc  <= r_coll_acc | w_hits;
      end
    end
  end

  assign collision     = r_collision;
  assign collision_stb = r_coll_stb;
`else
  assign collision     = '0;
  assign collision_stb = 1'b0;
`endif

endmodule
